rv32i_control: RTL and testbench
================================

// Module: rv32i_control
// PURPOSE
//  RV32I main decoder of the single-cycle datapath. Turns the fetched 32-bit instruction plus branch-comparator flags into datapath selects.
//  Decode is purely combinational (zero latency); clk/rst serve only the registered illegal-instruction flag.
// PARAMETERS
//  DWIDTH  32  datapath/instruction width; only 32 is supported
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  instruction  in   32 current instruction
//  BrEq         in   1  comparator: rs1 == rs2
//  BrLT         in   1  comparator: rs1 < rs2 (signedness per BrUn)
//  PCSel        out  1  0=PC+4, 1=ALU result (taken branch, JAL, JALR)
//  ImmSel       out  3  0=I 1=S 2=B 3=U 4=J
//  RegWEn       out  1  register-file write enable
//  BrUn         out  1  1 = unsigned compare (funct3 11x of BRANCH)
//  BSel         out  1  0=rs2, 1=immediate
//  ASel         out  1  0=rs1, 1=PC
//  ALUSel       out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  MemRW        out  1  1 = store (memory write)
//  WBSel        out  2  0=MEM, 1=ALU, 2=PC+4
//  TypeSel      out  3  memory access type = funct3 for LOAD/STORE, else 3'b010
//  Illegal      out  1  registered sticky illegal-instruction flag
// BEHAVIOUR
//  - OP (0110011): ALUSel from {funct7[5],funct3}; SUB/SRA need funct7=0100000, others funct7=0; RegWEn=1, WBSel=ALU.
//  - OP-IMM (0010011): ImmSel=I, BSel=1; SRAI iff inst[30]=1 and funct3=101; SLLI/SRLI/SRAI need inst[31:25] in {0000000,0100000}.
//  - LOAD (0000011): ADD, ImmSel=I, BSel=1, WBSel=MEM, RegWEn=1; funct3 in {000,001,010,100,101}.
//  - STORE (0100011): ADD, ImmSel=S, BSel=1, MemRW=1, RegWEn=0; funct3 in {000,001,010}.
//  - BRANCH (1100011): ImmSel=B, ASel=1, BSel=1, ADD, RegWEn=0, BrUn=funct3[1].
//    PCSel = BEQ:BrEq, BNE:!BrEq, BLT/BLTU:BrLT, BGE/BGEU:!BrLT; funct3 010/011 illegal.
//  - JAL (1101111): ImmSel=J, ASel=1, BSel=1, ADD, PCSel=1, WBSel=PC+4, RegWEn=1.
//  - JALR (1100111, funct3=000): ImmSel=I, ASel=0, BSel=1, ADD, PCSel=1, WBSel=PC+4, RegWEn=1.
//  - LUI (0110111): ImmSel=U, BSel=1, PASSB, WBSel=ALU, RegWEn=1.
//  - AUIPC (0010111): ImmSel=U, ASel=1, BSel=1, ADD, WBSel=ALU, RegWEn=1.
//  - FENCE / SYSTEM (0001111/1110011): legal no-ops.
//  - Defaults for every output not listed above: PCSel=0, RegWEn=0, MemRW=0, ASel=0, BSel=0, ALUSel=ADD, ImmSel=I, WBSel=ALU, BrUn=0, TypeSel=010.
//  - Illegal: inst[1:0]!=11, unknown opcode, or bad funct3/funct7 (incl. 32'h0); outputs take the defaults above.
//  - Illegal register: rst=1 clears it at the next rising edge; otherwise it sets (and holds) at the edge where the decoded instruction is illegal.
//  - Outputs are X-free for any input, including X-free defaults.
// CONFIGURATION
//  CTRL_ILLEGAL_SQUASH_EN
//   - Defined: when the current instruction is illegal, RegWEn, MemRW and PCSel are forced to 0 combinationally, even if opcode bits partially match.
//   - Undefined: the default path alone governs illegal instructions; the Illegal flag behaves identically.
// STRUCTURE
//  - Package rv32i_ctrl_pkg: opcode localparams; ALUSel, ImmSel and WBSel encodings; funct3 branch/mem codes.
//  - One sub-module, rv32i_branch_eval: (funct3, BrEq, BrLT) -> taken.
//  - Top: combinational case on opcode plus the Illegal register.
// TESTING
//  - 32'h000102b3 ADD -> ALUSel=0, RegWEn=1, WBSel=1, BSel=0, PCSel=0, MemRW=0; 32'h400102b3 -> ALUSel=1; 32'h400152b3 -> ALUSel=7.
//  - 32'hFF718393 ADDI -> ImmSel=0, BSel=1, ALUSel=0, RegWEn=1.
//  - 32'h02728863 BEQ: BrEq=1 -> PCSel=1, ImmSel=2, ASel=1, BSel=1, RegWEn=0; BrEq=0 -> PCSel=0.
//  - 32'h0471AA23 SW -> MemRW=1, ImmSel=1, TypeSel=010, RegWEn=0; 32'h06002103 LW -> WBSel=0, RegWEn=1, MemRW=0.
//  - 32'h008001EF JAL -> PCSel=1, ImmSel=4, ASel=1, WBSel=2, RegWEn=1.
//  - 32'h00000000 -> RegWEn=0, MemRW=0, Illegal=1 after next edge; rst=1 for one edge -> Illegal=0.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, datapath select codes
// and the funct3/funct7 values the decoder distinguishes.
package rv32i_ctrl_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ALU_SEL_W = 4;
  localparam int unsigned IMM_SEL_W = 3;
  localparam int unsigned WB_SEL_W  = 2;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;
  localparam int unsigned OPCODE_W  = 7;

  // Major opcodes
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

  // ALUSel encodings
  localparam logic [ALU_SEL_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_SEL_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_SEL_W-1:0] ALU_PASSB = 4'd10;

  // ImmSel encodings
  localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;

  // WBSel encodings
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd0;
  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd1;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;

  // Branch funct3
  localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

  // Memory access funct3 (loads use all five, stores the first three)
  localparam logic [FUNCT3_W-1:0] F3_MEM_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_MEM_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_MEM_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_MEM_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_MEM_HU = 3'b101;

  // Arithmetic funct3 values that accept the alternate funct7
  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;

  localparam logic [FUNCT7_W-1:0] F7_ZERO = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

  localparam logic [FUNCT3_W-1:0] TYPE_DEFAULT = 3'b010;

  // ALU operation for an arithmetic funct3; alt selects SUB/SRA.
  function automatic logic [ALU_SEL_W-1:0] alu_from_funct3(input logic [FUNCT3_W-1:0] f3,
                                                           input logic alt);
    logic [ALU_SEL_W-1:0] sel;
    case (f3)
      3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rv32i_branch_eval.sv
// Branch outcome from funct3 and the comparator flags.
//   funct3  in  3  branch condition code
//   br_eq   in  1  rs1 == rs2
//   br_lt   in  1  rs1 <  rs2 (signedness chosen upstream)
//   taken   out 1  combinational branch-taken (0 for reserved codes)
module rv32i_branch_eval
  import rv32i_ctrl_pkg::*;
(
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                br_eq,
  input  logic                br_lt,
  output logic                taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = br_eq;
      F3_BNE:           taken = ~br_eq;
      F3_BLT, F3_BLTU:  taken = br_lt;
      F3_BGE, F3_BGEU:  taken = ~br_lt;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_control.sv
// RV32I main decoder for the single-cycle datapath. Decode is combinational;
// only the sticky Illegal flag is registered.
//   clk, rst (sync, active-high)   -- Illegal register only
//   instruction, BrEq, BrLT        -- decode inputs
//   PCSel ImmSel RegWEn BrUn BSel ASel ALUSel MemRW WBSel TypeSel -- comb selects
//   Illegal                        -- registered sticky illegal-instruction flag
// Build option: CTRL_ILLEGAL_SQUASH_EN forces RegWEn/MemRW/PCSel low on illegal
// instructions as an explicit override on top of the decode.
module rv32i_control
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    instruction,
  input  logic                 BrEq,
  input  logic                 BrLT,
  output logic                 PCSel,
  output logic [IMM_SEL_W-1:0] ImmSel,
  output logic                 RegWEn,
  output logic                 BrUn,
  output logic                 BSel,
  output logic                 ASel,
  output logic [ALU_SEL_W-1:0] ALUSel,
  output logic                 MemRW,
  output logic [WB_SEL_W-1:0]  WBSel,
  output logic [FUNCT3_W-1:0]  TypeSel,
  output logic                 Illegal
);

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT3_W-1:0] funct3;
  logic [FUNCT7_W-1:0] funct7;
  logic                br_taken;
  logic                illegal_c;
  logic                unused_fields;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Register specifiers and immediate bits are not needed for control.
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  rv32i_branch_eval u_branch_eval (
    .funct3 (funct3),
    .br_eq  (BrEq),
    .br_lt  (BrLT),
    .taken  (br_taken)
  );

  // Main decode: each opcode only drives outputs once its funct fields are
  // known legal, so illegal encodings leave every output at its default.
  always_comb begin
    PCSel     = 1'b0;
    ImmSel    = IMM_I;
    RegWEn    = 1'b0;
    BrUn      = 1'b0;
    BSel      = 1'b0;
    ASel      = 1'b0;
    ALUSel    = ALU_ADD;
    MemRW     = 1'b0;
    WBSel     = WB_ALU;
    TypeSel   = TYPE_DEFAULT;
    illegal_c = 1'b0;

    case (opcode)
      OPC_OP: begin
        if ((funct7 == F7_ZERO) ||
            ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)))) begin
          ALUSel = alu_from_funct3(funct3, funct7[5]);
          RegWEn = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Shift-immediates carry funct7 in the immediate field; others do not.
        if (((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) &&
            (funct7 != F7_ZERO) && (funct7 != F7_ALT)) begin
          illegal_c = 1'b1;
        end else begin
          ALUSel = alu_from_funct3(funct3, (funct3 == F3_SRL_SRA) && instruction[30]);
          BSel   = 1'b1;
          RegWEn = 1'b1;
        end
      end
      OPC_LOAD: begin
        if ((funct3 == F3_MEM_B) || (funct3 == F3_MEM_H) || (funct3 == F3_MEM_W) ||
            (funct3 == F3_MEM_BU) || (funct3 == F3_MEM_HU)) begin
          BSel    = 1'b1;
          WBSel   = WB_MEM;
          RegWEn  = 1'b1;
          TypeSel = funct3;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_STORE: begin
        if ((funct3 == F3_MEM_B) || (funct3 == F3_MEM_H) || (funct3 == F3_MEM_W)) begin
          ImmSel  = IMM_S;
          BSel    = 1'b1;
          MemRW   = 1'b1;
          TypeSel = funct3;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
          ImmSel = IMM_B;
          ASel   = 1'b1;
          BSel   = 1'b1;
          BrUn   = funct3[1];
          PCSel  = br_taken;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_JAL: begin
        ImmSel = IMM_J;
        ASel   = 1'b1;
        BSel   = 1'b1;
        PCSel  = 1'b1;
        WBSel  = WB_PC4;
        RegWEn = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          BSel   = 1'b1;
          PCSel  = 1'b1;
          WBSel  = WB_PC4;
          RegWEn = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_LUI: begin
        ImmSel = IMM_U;
        BSel   = 1'b1;
        ALUSel = ALU_PASSB;
        RegWEn = 1'b1;
      end
      OPC_AUIPC: begin
        ImmSel = IMM_U;
        ASel   = 1'b1;
        BSel   = 1'b1;
        RegWEn = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        illegal_c = 1'b0;
      end
      default: begin
        // Also catches every encoding with instruction[1:0] != 2'b11.
        illegal_c = 1'b1;
      end
    endcase

`ifdef CTRL_ILLEGAL_SQUASH_EN
    // Explicit guard on the architecturally visible side effects.
    if (illegal_c) begin
      RegWEn = 1'b0;
      MemRW  = 1'b0;
      PCSel  = 1'b0;
    end
`else
    // Illegal encodings already leave side-effect outputs at their defaults.
`endif
  end

  // Sticky illegal-instruction flag; reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      Illegal <= 1'b0;
    end else if (illegal_c) begin
      Illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_control.sv
// Self-checking bench for rv32i_control: directed vector table, a sticky-flag
// sequence, then random instructions against a behavioural decode model.
module tb_rv32i_control;

  typedef struct packed {
    logic       pcsel;
    logic [2:0] immsel;
    logic       regwen;
    logic       brun;
    logic       bsel;
    logic       asel;
    logic [3:0] alusel;
    logic       memrw;
    logic [1:0] wbsel;
    logic [2:0] typesel;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        breq;
    logic        brlt;
    out_t        exp;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        BrEq, BrLT;
  logic        PCSel, RegWEn, BrUn, BSel, ASel, MemRW, Illegal;
  logic [2:0]  ImmSel, TypeSel;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel;
  out_t        act;

  int total = 0;
  int bad   = 0;

  rv32i_control dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .BrEq        (BrEq),
    .BrLT        (BrLT),
    .PCSel       (PCSel),
    .ImmSel      (ImmSel),
    .RegWEn      (RegWEn),
    .BrUn        (BrUn),
    .BSel        (BSel),
    .ASel        (ASel),
    .ALUSel      (ALUSel),
    .MemRW       (MemRW),
    .WBSel       (WBSel),
    .TypeSel     (TypeSel),
    .Illegal     (Illegal)
  );

  assign act = {PCSel, ImmSel, RegWEn, BrUn, BSel, ASel, ALUSel, MemRW, WBSel, TypeSel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(logic pc, logic [2:0] imm, logic rw, logic bu, logic b,
                              logic a, logic [3:0] alu, logic mw, logic [1:0] wb,
                              logic [2:0] ty);
    out_t o;
    o = {pc, imm, rw, bu, b, a, alu, mw, wb, ty};
    return o;
  endfunction

  function automatic out_t dflt();
    return mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd1, 3'd2);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Behavioural decode: instruction classes by opcode, ALU op by table lookup
  // (SUB = ADD+1 and SRA = SRL+1 in the select encoding).
  function automatic void ref_model(input logic [31:0] i, input logic breq, input logic brlt,
                                    output out_t o, output logic ill);
    logic [3:0] base [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       cond;
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc  = i[6:0];
    f3   = i[14:12];
    f7   = i[31:25];
    o    = dflt();
    ill  = 1'b0;
    case (opc)
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
               o.regwen = 1'b1;
               o.alusel = base[f3] + 4'((f7 == 7'h20) ? 1 : 0);
             end else ill = 1'b1;
      7'h13: if ((f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20)) ill = 1'b1;
             else begin
               o.regwen = 1'b1;
               o.bsel   = 1'b1;
               o.alusel = base[f3] + 4'((f3 == 3'd5 && i[30]) ? 1 : 0);
             end
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
               o.regwen = 1'b1; o.bsel = 1'b1; o.wbsel = 2'd0; o.typesel = f3;
             end else ill = 1'b1;
      7'h23: if (f3 <= 3'd2) begin
               o.memrw = 1'b1; o.immsel = 3'd1; o.bsel = 1'b1; o.typesel = f3;
             end else ill = 1'b1;
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
               cond = f3[2] ? brlt : breq;
               o.pcsel = cond ^ f3[0];
               o.immsel = 3'd2; o.asel = 1'b1; o.bsel = 1'b1; o.brun = f3[1];
             end else ill = 1'b1;
      7'h6f: o = mk(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd2, 3'd2);
      7'h67: if (f3 == 3'd0) o = mk(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd2, 3'd2);
             else ill = 1'b1;
      7'h37: o = mk(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 2'd1, 3'd2);
      7'h17: o = mk(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1, 3'd2);
      7'h0f, 7'h73: ill = 1'b0;
      default: ill = 1'b1;
    endcase
  endfunction

  vec_t       tbl[$];
  logic [6:0] opcs [11];
  out_t       m_out;
  logic       m_ill;
  logic       ill_m;

  initial begin
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};

    tbl.push_back('{"add",      32'h000102b3, 1'b0, 1'b0, mk(0,3'd0,1,0,0,0,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"sub",      32'h400102b3, 1'b0, 1'b0, mk(0,3'd0,1,0,0,0,4'd1,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"sra",      32'h400152b3, 1'b0, 1'b0, mk(0,3'd0,1,0,0,0,4'd7,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"sub_f3",   32'h400112b3, 1'b0, 1'b0, dflt(), 1'b1});
    tbl.push_back('{"addi",     32'hFF718393, 1'b0, 1'b0, mk(0,3'd0,1,0,1,0,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"srai",     32'h4050d093, 1'b0, 1'b0, mk(0,3'd0,1,0,1,0,4'd7,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"slli_bad", 32'h02009093, 1'b0, 1'b0, dflt(), 1'b1});
    tbl.push_back('{"beq_t",    32'h02728863, 1'b1, 1'b0, mk(1,3'd2,0,0,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"beq_nt",   32'h02728863, 1'b0, 1'b1, mk(0,3'd2,0,0,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"bne_nt",   32'h00209063, 1'b1, 1'b0, mk(0,3'd2,0,0,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"blt_t",    32'h0020c063, 1'b0, 1'b1, mk(1,3'd2,0,0,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"bgeu_t",   32'h0020f063, 1'b1, 1'b0, mk(1,3'd2,0,1,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"bgeu_nt",  32'h0020f063, 1'b0, 1'b1, mk(0,3'd2,0,1,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"sw",       32'h0471AA23, 1'b0, 1'b0, mk(0,3'd1,0,0,1,0,4'd0,1,2'd1,3'd2), 1'b0});
    tbl.push_back('{"st_bad",   32'h0000b023, 1'b1, 1'b1, dflt(), 1'b1});
    tbl.push_back('{"lw",       32'h06002103, 1'b0, 1'b0, mk(0,3'd0,1,0,1,0,4'd0,0,2'd0,3'd2), 1'b0});
    tbl.push_back('{"lbu",      32'h00004003, 1'b0, 1'b0, mk(0,3'd0,1,0,1,0,4'd0,0,2'd0,3'd4), 1'b0});
    tbl.push_back('{"ld_bad",   32'h00003003, 1'b0, 1'b0, dflt(), 1'b1});
    tbl.push_back('{"jal",      32'h008001EF, 1'b0, 1'b0, mk(1,3'd4,1,0,1,1,4'd0,0,2'd2,3'd2), 1'b0});
    tbl.push_back('{"jalr",     32'h000280e7, 1'b0, 1'b0, mk(1,3'd0,1,0,1,0,4'd0,0,2'd2,3'd2), 1'b0});
    tbl.push_back('{"jalr_bad", 32'h000290e7, 1'b0, 1'b0, dflt(), 1'b1});
    tbl.push_back('{"lui",      32'h000012b7, 1'b0, 1'b0, mk(0,3'd3,1,0,1,0,4'd10,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"auipc",    32'h00001297, 1'b0, 1'b0, mk(0,3'd3,1,0,1,1,4'd0,0,2'd1,3'd2), 1'b0});
    tbl.push_back('{"fence",    32'h0000000f, 1'b0, 1'b0, dflt(), 1'b0});
    tbl.push_back('{"ecall",    32'h00000073, 1'b0, 1'b0, dflt(), 1'b0});
    tbl.push_back('{"lowbits",  32'h000102b0, 1'b0, 1'b0, dflt(), 1'b1});
    tbl.push_back('{"zero",     32'h00000000, 1'b0, 1'b0, dflt(), 1'b1});

    // Reset state
    rst = 1'b1; instruction = 32'h0000_0013; BrEq = 1'b0; BrLT = 1'b0;
    @(posedge clk); #1;
    check("reset_illegal", 32'(Illegal), 32'd0);

    // Directed table: comb outputs, then Illegal after one edge, then clear.
    foreach (tbl[k]) begin
      @(negedge clk);
      rst = 1'b0; instruction = tbl[k].instr; BrEq = tbl[k].breq; BrLT = tbl[k].brlt;
      #1;
      check({tbl[k].name, "_out"}, 32'(act), 32'(tbl[k].exp));
      @(posedge clk); #1;
      check({tbl[k].name, "_ill"}, 32'(Illegal), 32'(tbl[k].ill));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
    end

    // Sticky flag: one illegal word, then legal ones; reset wins over illegal.
    @(negedge clk); rst = 1'b0; instruction = 32'h0;
    @(negedge clk); instruction = 32'h000102b3;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check("sticky_hold", 32'(Illegal), 32'd1);
    end
    @(negedge clk); rst = 1'b1; instruction = 32'h0;
    @(posedge clk); #1;
    check("rst_over_illegal", 32'(Illegal), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("set_after_rst", 32'(Illegal), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    ill_m = 1'b0;

    // Random instructions against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic [6:0]  opc;
      logic [6:0]  f7;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 11);
      opc = (k == 11) ? 7'($urandom) : opcs[k];
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      @(negedge clk);
      rst = ($urandom_range(0, 15) == 0);
      instruction = {f7, r[24:7], opc};
      BrEq = 1'($urandom); BrLT = 1'($urandom);
      ref_model(instruction, BrEq, BrLT, m_out, m_ill);
      #1;
      check("rand_out", 32'(act), 32'(m_out));
      @(posedge clk); #1;
      ill_m = rst ? 1'b0 : (ill_m | m_ill);
      check("rand_ill", 32'(Illegal), 32'(ill_m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
